// File: rtl/mips_irq_pkg.sv
// mips_irq_pkg: register map, CTRL bit positions and service FSM encoding
// shared by the MIPS interrupt controller.
package mips_irq_pkg;

    localparam logic [3:0] REG_CTRL     = 4'd0;
    localparam logic [3:0] REG_PEND     = 4'd1;
    localparam logic [3:0] REG_VEC_BASE = 4'd2;

    localparam int CTRL_GEN_BIT = 31;
    localparam int MAX_SRC      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } irq_state_e;

    // Register index of VEC[i].
    function automatic logic [3:0] vec_reg_idx(input int i);
        return REG_VEC_BASE + 4'(i);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set request index wins.
module irq_prio_enc #(
    parameter int N_SRC = 3
) (
    input  logic [N_SRC-1:0] req_i,
    output logic [2:0]       idx_o,
    output logic             valid_o
);

    always_comb begin
        // NOTE: outputs get a default before the loop so no path infers a latch.
        idx_o   = '0;
        valid_o = |req_i;
        // Scan downward so the last hit, the lowest index, is what remains.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/mips_irq_ctl.sv
// mips_irq_ctl: edge-detected interrupt sources, W1C pending register and a
// non-nesting IDLE/REQ/SERV service FSM. Define IRQ_CTL_SYNC_EN to add a 2-flop input synchronizer.
module mips_irq_ctl
    import mips_irq_pkg::*;
#(
    parameter int N_SRC = 3,
    parameter int VEC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_i,
    input  logic             reg_we,
    input  logic [3:0]       reg_idx,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    output logic             irq_req_o,
    output logic [VEC_W-1:0] irq_addr_o,
    input  logic             irq_ack_i,
    input  logic             irq_eoi_i,
    output logic [2:0]       irq_src_o
);

    logic               ctrl_gen_q, ctrl_gen_d;
    logic [N_SRC-1:0]   ctrl_en_q, ctrl_en_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [VEC_W-1:0]   vec_q [N_SRC];
    logic [VEC_W-1:0]   vec_d [N_SRC];
    logic [N_SRC-1:0]   prev_q, prev_d;
    logic [31:0]        rdata_q, rdata_d;
    irq_state_e         state_q, state_d;
    logic [VEC_W-1:0]   addr_q, addr_d;
    logic [2:0]         src_q, src_d;

    logic [N_SRC-1:0]   sample, rise, w1c, ack_clr, pend_en;
    logic [MAX_SRC-1:0] en_ext;
    logic               win_en, wr_ctrl, wr_pend;
    logic [2:0]         enc_idx;
    logic               enc_valid;
    logic [VEC_W-1:0]   enc_vec;

`ifdef IRQ_CTL_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    assign sync1_d = src_i;
    assign sync2_d = sync1_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = src_i;
`endif

    assign pend_en = pend_q & ctrl_en_q;

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .req_i   (pend_en),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    // The request is only live while both the global and the winner's enable hold.
    assign en_ext = MAX_SRC'(ctrl_en_q);
    assign win_en = ctrl_gen_q & en_ext[src_q];

    always_comb begin
        wr_ctrl = reg_we && (reg_idx == REG_CTRL);
        wr_pend = reg_we && (reg_idx == REG_PEND);
        rise    = sample & ~prev_q;
        prev_d  = sample;
        w1c     = wr_pend ? reg_wdata[N_SRC-1:0] : '0;

        ctrl_gen_d = ctrl_gen_q;
        ctrl_en_d  = ctrl_en_q;
        if (wr_ctrl) begin
            ctrl_gen_d = reg_wdata[CTRL_GEN_BIT];
            ctrl_en_d  = reg_wdata[N_SRC-1:0];
        end

        vec_d   = vec_q;
        enc_vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (reg_we && (reg_idx == vec_reg_idx(i))) begin
                vec_d[i] = VEC_W'(reg_wdata);
            end
            if (enc_idx == 3'(i)) begin
                enc_vec = vec_q[i];
            end
        end

        rdata_d = '0;
        if (reg_idx == REG_CTRL) begin
            rdata_d[CTRL_GEN_BIT] = ctrl_gen_q;
            rdata_d[N_SRC-1:0]    = ctrl_en_q;
        end else if (reg_idx == REG_PEND) begin
            rdata_d[N_SRC-1:0] = pend_q;
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (reg_idx == vec_reg_idx(i)) begin
                rdata_d = 32'(vec_q[i]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        src_d   = src_q;
        ack_clr = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_gen_q && enc_valid) begin
                    state_d = ST_REQ;
                    src_d   = enc_idx;
                    addr_d  = enc_vec;
                end
            end
            ST_REQ: begin
                if (!win_en) begin
                    state_d = ST_IDLE;
                end else if (irq_ack_i) begin
                    state_d = ST_SERV;
                    for (int i = 0; i < N_SRC; i++) begin
                        ack_clr[i] = (src_q == 3'(i));
                    end
                end
            end
            ST_SERV: begin
                if (irq_eoi_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh edge outranks both the W1C write and the ack clear.
        pend_d = (pend_q & ~w1c & ~ack_clr) | rise;
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_gen_q <= 1'b0;
            ctrl_en_q  <= '0;
            pend_q     <= '0;
            // NOTE: the vector table is reset too, so a fetched vector is never X.
            vec_q      <= '{default: '0};
            prev_q     <= '0;
            rdata_q    <= '0;
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            src_q      <= '0;
        end else begin
            ctrl_gen_q <= ctrl_gen_d;
            ctrl_en_q  <= ctrl_en_d;
            pend_q     <= pend_d;
            vec_q      <= vec_d;
            prev_q     <= prev_d;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
        end
    end

    assign irq_req_o  = (state_q == ST_REQ) && win_en;
    assign irq_addr_o = addr_q;
    assign irq_src_o  = src_q;
    assign reg_rdata  = rdata_q;

endmodule

// File: tb/tb_mips_irq_ctl.sv
// tb_mips_irq_ctl: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the interrupt controller.
module tb_mips_irq_ctl;

    localparam int N = 3;
`ifdef IRQ_CTL_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_SERV = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  src_i = '0;
    logic          reg_we = 1'b0;
    logic [3:0]    reg_idx = '0;
    logic [31:0]   reg_wdata = '0;
    logic [31:0]   reg_rdata;
    logic          irq_req_o;
    logic [31:0]   irq_addr_o;
    logic          irq_ack_i = 1'b0;
    logic          irq_eoi_i = 1'b0;
    logic [2:0]    irq_src_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state.
    logic [31:0]  m_ctrl;
    logic [N-1:0] m_pend;
    logic [31:0]  m_vec [N];
    logic [N-1:0] m_prev, m_s1, m_s2;
    int           m_phase;
    int           m_win;
    logic [31:0]  m_addr;
    logic [31:0]  m_rdata;

    mips_irq_ctl #(.N_SRC(N), .VEC_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_i      (src_i),
        .reg_we     (reg_we),
        .reg_idx    (reg_idx),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .irq_req_o  (irq_req_o),
        .irq_addr_o (irq_addr_o),
        .irq_ack_i  (irq_ack_i),
        .irq_eoi_i  (irq_eoi_i),
        .irq_src_o  (irq_src_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Apply the specification's rules for one rising edge, using the inputs present at it.
    task automatic model_edge();
        logic [N-1:0] smp, rise, w1c, ackclr, en;
        logic         gen;
        int           idx;
        if (!rst) begin
            m_ctrl = '0; m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
            for (int i = 0; i < N; i++) m_vec[i] = '0;
            m_phase = PH_IDLE; m_win = 0; m_addr = '0; m_rdata = '0;
        end else begin
            smp = (SL == 0) ? src_i : m_s2;
            idx = int'(reg_idx);
            if (idx == 0)                   m_rdata = m_ctrl;
            else if (idx == 1)              m_rdata = 32'(m_pend);
            else if (idx >= 2 && idx < 2+N) m_rdata = m_vec[idx-2];
            else                            m_rdata = '0;

            rise   = smp & ~m_prev;
            gen    = m_ctrl[31];
            en     = m_ctrl[N-1:0];
            ackclr = '0;
            if (m_phase == PH_IDLE) begin
                if (gen && ((m_pend & en) != 0)) begin
                    for (int i = N - 1; i >= 0; i--) if (m_pend[i] && en[i]) m_win = i;
                    m_addr  = m_vec[m_win];
                    m_phase = PH_REQ;
                end
            end else if (m_phase == PH_REQ) begin
                if (!(gen && en[m_win])) m_phase = PH_IDLE;
                else if (irq_ack_i) begin
                    ackclr[m_win] = 1'b1;
                    m_phase = PH_SERV;
                end
            end else if (irq_eoi_i) begin
                m_phase = PH_IDLE;
            end

            w1c    = (reg_we && idx == 1) ? reg_wdata[N-1:0] : '0;
            m_pend = (m_pend & ~w1c & ~ackclr) | rise;
            if (reg_we && idx == 0)                   m_ctrl = reg_wdata & 32'h8000_0007;
            if (reg_we && idx >= 2 && idx < 2+N)      m_vec[idx-2] = reg_wdata;
            m_prev = smp;
            m_s2   = m_s1;
            m_s1   = src_i;
        end
    endtask

    // One clock: update model at the edge, compare all outputs 1 time unit later, end pulses.
    task automatic tick();
        logic exp_req;
        @(posedge clk);
        model_edge();
        #1;
        exp_req = (m_phase == PH_REQ) && m_ctrl[31] && m_ctrl[m_win];
        check("req",   32'(irq_req_o), 32'(exp_req));
        check("addr",  irq_addr_o,     m_addr);
        check("src",   32'(irq_src_o), 32'(m_win));
        check("rdata", reg_rdata,      m_rdata);
        reg_we    = 1'b0;
        irq_ack_i = 1'b0;
        irq_eoi_i = 1'b0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] data);
        reg_we = 1'b1; reg_idx = idx; reg_wdata = data;
        tick();
    endtask

    task automatic rd(input logic [3:0] idx, input logic [31:0] exp, input string tag);
        reg_idx = idx;
        tick();
        check(tag, reg_rdata, exp);
    endtask

    initial begin
        // Reset state.
        rst = 1'b0;
        tick(); tick();
        check("rst_req",   32'(irq_req_o), 32'd0);
        check("rst_addr",  irq_addr_o,     32'd0);
        check("rst_src",   32'(irq_src_o), 32'd0);
        check("rst_rdata", reg_rdata,      32'd0);
        rst = 1'b1;
        rd(4'd0, 32'd0, "rst_ctrl");
        rd(4'd1, 32'd0, "rst_pend");

        // Single key1 request, two edges of latency, ack clears pending.
        wr(4'd0, 32'h8000_0007);
        wr(4'd2, 32'h0000_0100);
        wr(4'd3, 32'h0000_0400);
        wr(4'd4, 32'h0000_0800);
        rd(4'd0, 32'h8000_0007, "ctrl_rb");
        src_i[1] = 1'b1;
        tick();
        repeat (SL) tick();
        check("k1_early", 32'(irq_req_o), 32'd0);
        tick();
        check("k1_req",  32'(irq_req_o), 32'd1);
        check("k1_addr", irq_addr_o,     32'h0000_0400);
        check("k1_src",  32'(irq_src_o), 32'd1);
        irq_ack_i = 1'b1;
        tick();
        check("k1_ack_req", 32'(irq_req_o), 32'd0);
        src_i = '0;
        rd(4'd1, 32'd0, "k1_pend");
        irq_eoi_i = 1'b1;
        tick();

        // Timer and key2 together: timer first, key2 one edge after eoi.
        src_i = 3'b101;
        tick();
        repeat (SL) tick();
        tick();
        check("t_req",  32'(irq_req_o), 32'd1);
        check("t_src",  32'(irq_src_o), 32'd0);
        check("t_addr", irq_addr_o,     32'h0000_0100);
        irq_ack_i = 1'b1;
        tick();
        src_i = '0;
        check("t_serv_req", 32'(irq_req_o), 32'd0);
        tick();
        check("nonest_req", 32'(irq_req_o), 32'd0);
        irq_eoi_i = 1'b1;
        tick();
        check("eoi_edge_req", 32'(irq_req_o), 32'd0);
        tick();
        check("k2_req",  32'(irq_req_o), 32'd1);
        check("k2_src",  32'(irq_src_o), 32'd2);
        check("k2_addr", irq_addr_o,     32'h0000_0800);
        irq_ack_i = 1'b1; tick();
        irq_eoi_i = 1'b1; tick();

        // Global enable off holds requests back; turning it on releases them.
        wr(4'd0, 32'h0000_0007);
        src_i[0] = 1'b1;
        tick();
        repeat (SL) tick();
        tick();
        check("gen_off_req", 32'(irq_req_o), 32'd0);
        rd(4'd1, 32'd1, "gen_off_pend");
        wr(4'd0, 32'h8000_0007);
        check("gen_on_write_edge", 32'(irq_req_o), 32'd0);
        tick();
        check("gen_on_req",  32'(irq_req_o), 32'd1);
        check("gen_on_addr", irq_addr_o,     32'h0000_0100);

        // Withdraw while in REQ, then reissue.
        wr(4'd0, 32'h0000_0007);
        check("wd_req", 32'(irq_req_o), 32'd0);
        tick();
        check("wd_idle_req", 32'(irq_req_o), 32'd0);
        rd(4'd1, 32'd1, "wd_pend");
        wr(4'd0, 32'h8000_0007);
        tick();
        check("reissue_req", 32'(irq_req_o), 32'd1);
        check("reissue_src", 32'(irq_src_o), 32'd0);
        irq_ack_i = 1'b1; tick();
        irq_eoi_i = 1'b1; tick();

        // W1C against a simultaneous edge, then W1C alone.
        wr(4'd0, 32'h0000_0000);
        src_i[0] = 1'b0;
        tick();
        src_i[0] = 1'b1;
        repeat (SL) tick();
        wr(4'd1, 32'h0000_0001);
        rd(4'd1, 32'd1, "w1c_vs_set");
        wr(4'd1, 32'h0000_0001);
        rd(4'd1, 32'd0, "w1c_alone");

        // Vector writes during REQ and SERV leave irq_addr_o alone.
        wr(4'd0, 32'h8000_0007);
        src_i[2] = 1'b1;
        tick();
        repeat (SL) tick();
        tick();
        check("vw_req",  32'(irq_req_o), 32'd1);
        check("vw_addr", irq_addr_o,     32'h0000_0800);
        wr(4'd4, 32'hDEAD_0000);
        check("vw_req_addr", irq_addr_o, 32'h0000_0800);
        irq_ack_i = 1'b1;
        tick();
        wr(4'd4, 32'hBEEF_0000);
        check("vw_serv_addr", irq_addr_o, 32'h0000_0800);
        rd(4'd4, 32'hBEEF_0000, "vw_rb");

        // Reset during SERV; a later eoi does nothing.
        src_i = '0;
        rst = 1'b0;
        tick();
        check("srst_req",   32'(irq_req_o), 32'd0);
        check("srst_addr",  irq_addr_o,     32'd0);
        check("srst_src",   32'(irq_src_o), 32'd0);
        check("srst_rdata", reg_rdata,      32'd0);
        rst = 1'b1;
        irq_eoi_i = 1'b1;
        tick();
        check("post_eoi_req", 32'(irq_req_o), 32'd0);
        rd(4'd0, 32'd0, "srst_ctrl");
        wr(4'd5, 32'h1234_5678);
        rd(4'd5, 32'd0, "undef_idx5");
        rd(4'd15, 32'd0, "undef_idx15");

        // Randomized traffic against the model.
        wr(4'd2, 32'h0000_1000);
        wr(4'd3, 32'h0000_2000);
        wr(4'd4, 32'h0000_3000);
        wr(4'd0, 32'h8000_0007);
        for (int c = 0; c < 3000; c++) begin
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(3, 0) == 0) src_i[j] = ~src_i[j];
            end
            reg_idx = ($urandom_range(9, 0) == 0) ? 4'(15) : 4'($urandom_range(6, 0));
            reg_wdata = $urandom;
            if ($urandom_range(3, 0) != 0) reg_wdata[31] = 1'b1;
            reg_we    = ($urandom_range(7, 0) == 0);
            irq_ack_i = ($urandom_range(2, 0) == 0);
            irq_eoi_i = ($urandom_range(3, 0) == 0);
            rst       = ($urandom_range(199, 0) != 0);
            tick();
            rst = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
